// File: rtl/send_row.sv
// send_row: row serializer between the row source and the DCNN datapath.
//
// Latches one ROW_W-bit row while `ready` is high in IDLE, then streams it out
// as NWORDS = ROW_W/BUS_W words of BUS_W bits, most significant word first.
// After the last word is accepted, `send` pulses for one cycle to request the
// next row. The block then idles for GAP_CYCLES cycles so the producer can
// update `row` before it may be latched again.
//
// Handshake: a word transfers on a rising clk edge where out_valid && out_ready;
// out_data (and out_parity) stay constant while out_valid=1 and out_ready=0,
// and out_valid never drops before its word has been accepted.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-low reset
//   row        in   ROW_W  row data, bit ROW_W-1 is sent first; sampled at latch only
//   ready      in   high = `row` holds a valid new row (level)
//   send       out  one-cycle pulse: row fully transmitted, request next row
//   out_data   out  BUS_W  current output word
//   out_valid  out  out_data valid
//   out_ready  in   downstream accepts the current word
//   busy       out  high in any state other than IDLE
//   out_parity out  XOR of out_data (only when SEND_ROW_PARITY_EN is defined)
//   dbg_state  out  current FSM state (0 IDLE, 1 XFER, 2 DONE, 3 GAP)
//
// Optional feature macro: SEND_ROW_PARITY_EN adds the out_parity output.
// All outputs are registered.

module send_row #(
    parameter int ROW_W      = 480,
    parameter int BUS_W      = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ROW_W-1:0] row,
    input  logic             ready,
    output logic             send,
    output logic [BUS_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
`ifdef SEND_ROW_PARITY_EN
    output logic             out_parity,
`endif
    output logic [1:0]       dbg_state
);

    localparam int NWORDS = ROW_W / BUS_W;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [BUS_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             send_q, send_d;
    logic             busy_q, busy_d;
    logic             accept;

    assign accept = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        send_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ready) begin
                    shift_d     = row;
                    cnt_d       = '0;
                    out_data_d  = row[ROW_W-1 -: BUS_W];
                    out_valid_d = 1'b1;
                    state_d     = S_XFER;
                end
            end
            S_XFER: begin
                out_valid_d = 1'b1;
                if (accept) begin
                    shift_d = shift_q << BUS_W;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_WORD) begin
                        // Last word leaves this edge: raise send in DONE.
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        send_d      = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        out_data_d = shift_d[ROW_W-1 -: BUS_W];
                    end
                end
            end
            S_DONE: begin
                gap_d   = GAP_LOAD;
                state_d = S_GAP;
            end
            S_GAP: begin
                // `ready` is deliberately ignored here; the producer is
                // still updating `row` after the send pulse.
                gap_d = gap_q - GAP_W'(1);
                if (gap_q == GAP_W'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            send_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            send_q      <= send_d;
            busy_q      <= busy_d;
        end
    end

`ifdef SEND_ROW_PARITY_EN
    logic out_parity_q, out_parity_d;

    // Parity follows the word it describes and is forced low while no word is valid.
    always_comb begin
        out_parity_d = out_valid_d ? (^out_data_d) : 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_parity_q <= 1'b0;
        end else begin
            out_parity_q <= out_parity_d;
        end
    end

    assign out_parity = out_parity_q;
`endif

    assign send      = send_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_send_row.sv
// Testbench for send_row: scenario tasks with randomized rows and randomized
// out_ready stalls, checked against word lists derived from the row value.

module tb_send_row;

  localparam int ROW_W      = 480;
  localparam int BUS_W      = 16;
  localparam int GAP_CYCLES = 2;
  localparam int NWORDS     = ROW_W / BUS_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [ROW_W-1:0] row;
  logic             ready;
  logic             send;
  logic [BUS_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic [1:0]       dbg_state;
`ifdef SEND_ROW_PARITY_EN
  logic             out_parity;
`endif

  int checks = 0;
  int errors = 0;

  logic [BUS_W-1:0] exp_q[$];
  logic [BUS_W-1:0] got_q[$];
  logic             par_q[$];

  send_row #(
    .ROW_W(ROW_W),
    .BUS_W(BUS_W),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .row(row),
    .ready(ready),
    .send(send),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy),
`ifdef SEND_ROW_PARITY_EN
    .out_parity(out_parity),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  // Word k of a row is the k-th BUS_W-bit group counted from the top.
  function automatic logic [BUS_W-1:0] word_of(input logic [ROW_W-1:0] r, input int k);
    logic [ROW_W-1:0] t;
    t = r >> ((NWORDS - 1 - k) * BUS_W);
    return t[BUS_W-1:0];
  endfunction

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] r;
    r = '0;
    for (int i = 0; i < (ROW_W + 31) / 32; i++) r = (r << 32) | ROW_W'($urandom());
    return r;
  endfunction

  task automatic expect_words(input logic [ROW_W-1:0] r, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(word_of(r, k));
  endtask

  // ---------------- driver ----------------
  // Drives out_ready each negedge and records every word accepted on the
  // following posedge, until n words have been taken or the budget expires.
  task automatic pull_words(input int n, input int stall_pct, input bit keep_ready,
                            output int cycles, output bit timed_out);
    int acc;
    acc = 0;
    cycles = 0;
    timed_out = 1'b0;
    while (acc < n && !timed_out) begin
      @(negedge clk);
      if (!keep_ready) ready = 1'b0;
      if (cycles >= 4000) begin
        timed_out = 1'b1;
      end else begin
        out_ready = (int'($urandom_range(99)) >= stall_pct);
        if (out_valid && out_ready) begin
          got_q.push_back(out_data);
`ifdef SEND_ROW_PARITY_EN
          par_q.push_back(out_parity);
`endif
          acc++;
        end
        cycles++;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [ROW_W-1:0] r;
    int cyc;
    bit to;
    r = rand_row();
    rst = 1'b0;
    ready = 1'b1;
    row = r;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (send !== 1'b0) begin errors++; $display("FAIL reset_send: got %b want 0", send); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef SEND_ROW_PARITY_EN
    checks++; if (out_parity !== 1'b0) begin errors++; $display("FAIL reset_parity: got %b want 0", out_parity); end
`endif
    rst = 1'b1;
    expect_words(r, NWORDS);
    pull_words(NWORDS, 0, 1'b0, cyc, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL reset_release_timeout: row not delivered"); end
    checks++; if (cyc !== NWORDS) begin errors++; $display("FAIL reset_first_latch: took %0d cycles want %0d", cyc, NWORDS); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL reset_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL reset_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete(); got_q.delete(); par_q.delete();
    for (int i = 0; i < 20 && busy !== 1'b0; i++) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_single_row();
    logic [ROW_W-1:0] r;
    int cyc;
    bit to;
    r = '0;
    for (int k = 0; k < NWORDS; k++) r = (r << BUS_W) | ROW_W'(k);
    @(negedge clk);
    row = r;
    ready = 1'b1;
    expect_words(r, NWORDS);
    pull_words(NWORDS, 0, 1'b0, cyc, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL single_timeout: row not delivered"); end
    checks++; if (cyc !== NWORDS) begin errors++; $display("FAIL single_rate: took %0d cycles want %0d", cyc, NWORDS); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL single_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== BUS_W'(i)) begin errors++; $display("FAIL single_word%0d: got %h want %h", i, got_q[i], BUS_W'(i)); end
    end
    exp_q.delete(); got_q.delete(); par_q.delete();
    @(negedge clk);
    checks++; if (send !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL single_send: send=%b valid=%b want 1/0", send, out_valid); end
`ifdef SEND_ROW_PARITY_EN
    checks++; if (out_parity !== 1'b0) begin errors++; $display("FAIL single_parity_idle: got %b want 0", out_parity); end
`endif
    for (int g = 0; g < GAP_CYCLES; g++) begin
      @(negedge clk);
      checks++; if (send !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_gap%0d: send=%b busy=%b want 0/1", g, send, busy); end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop: got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    logic [ROW_W-1:0] r;
    int cyc;
    bit to;
    r = {NWORDS{16'hA5A5}};
    @(negedge clk);
    row = r;
    ready = 1'b1;
    pull_words(NWORDS, 50, 1'b0, cyc, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL bp_timeout: row not delivered"); end
    checks++; if (got_q.size() !== NWORDS) begin errors++; $display("FAIL bp_count: got %0d want %0d", got_q.size(), NWORDS); end
    foreach (got_q[i]) begin
      checks++; if (got_q[i] !== 16'hA5A5) begin errors++; $display("FAIL bp_word%0d: got %h want a5a5", i, got_q[i]); end
    end
    got_q.delete(); par_q.delete();
    @(negedge clk);
    checks++; if (send !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_send: send=%b valid=%b want 1/0", send, out_valid); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      out_ready = $urandom_range(1);
      checks++; if (out_valid !== 1'b0 || send !== 1'b0) begin errors++; $display("FAIL bp_extra%0d: valid=%b send=%b want 0/0", i, out_valid, send); end
    end
  endtask

  task automatic test_back_to_back();
    logic [ROW_W-1:0] rows[3];
    int sends;
    int idle_run;
    bit seen;
    int extra;
    for (int i = 0; i < 3; i++) begin
      rows[i] = rand_row();
      expect_words(rows[i], NWORDS);
    end
    @(negedge clk);
    row = rows[0];
    ready = 1'b1;
    out_ready = 1'b1;
    sends = 0;
    idle_run = 0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 400 && sends < 3; cyc++) begin
      @(negedge clk);
      if (send === 1'b1) begin
        sends++;
        if (sends < 3) row = rows[sends];
        else ready = 1'b0;
      end
      if (out_valid === 1'b1) begin
        if (seen && idle_run > 0) begin
          checks++; if (idle_run !== GAP_CYCLES + 2) begin errors++; $display("FAIL b2b_gap: got %0d idle cycles want %0d", idle_run, GAP_CYCLES + 2); end
        end
        idle_run = 0;
        got_q.push_back(out_data);
        seen = 1'b1;
      end else if (seen) begin
        idle_run++;
      end
    end
    checks++; if (sends !== 3) begin errors++; $display("FAIL b2b_sends: got %0d want 3", sends); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete(); got_q.delete(); par_q.delete();
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (send === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_extra_send: got %0d want 0", extra); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_disturb();
    logic [ROW_W-1:0] r0;
    logic [ROW_W-1:0] r1;
    int cyc;
    bit to;
    int sends;
    r0 = rand_row();
    r1 = rand_row();
    @(negedge clk);
    row = r0;
    ready = 1'b1;
    expect_words(r0, NWORDS);
    pull_words(5, 20, 1'b1, cyc, to);
    row = r1;
    ready = 1'b0;
    pull_words(NWORDS - 5, 20, 1'b0, cyc, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL disturb_timeout: row not delivered"); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL disturb_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL disturb_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete(); got_q.delete(); par_q.delete();
    for (int i = 0; i < 20 && busy !== 1'b0; i++) @(negedge clk);
    @(negedge clk);
    // Second row: reset it after 10 accepted words.
    ready = 1'b1;
    expect_words(r1, 10);
    pull_words(10, 30, 1'b0, cyc, to);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || send !== 1'b0) begin errors++; $display("FAIL abort_outputs: valid=%b busy=%b send=%b want 0/0/0", out_valid, busy, send); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL abort_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    exp_q.delete(); got_q.delete(); par_q.delete();
    sends = 0;
    repeat (3) begin
      @(negedge clk);
      if (send === 1'b1) sends++;
    end
    rst = 1'b1;
    ready = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (send === 1'b1) sends++;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", out_valid); end
    end
    checks++; if (sends !== 0) begin errors++; $display("FAIL abort_send: got %0d pulses want 0", sends); end
  endtask

  task automatic test_random_rows();
    logic [ROW_W-1:0] r;
    int cyc;
    bit to;
    int sends;
    for (int n = 0; n < 3; n++) begin
      r = rand_row();
      @(negedge clk);
      row = r;
      ready = 1'b1;
      expect_words(r, NWORDS);
      pull_words(NWORDS, int'($urandom_range(60, 10)), 1'b0, cyc, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL rand%0d_timeout: row not delivered", n); end
      checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", n, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_word%0d: got %h want %h", n, i, got_q[i], exp_q[i]); end
      end
`ifdef SEND_ROW_PARITY_EN
      for (int i = 0; i < exp_q.size() && i < par_q.size(); i++) begin
        checks++; if (par_q[i] !== ^exp_q[i]) begin errors++; $display("FAIL rand%0d_par%0d: got %b want %b", n, i, par_q[i], ^exp_q[i]); end
      end
`endif
      exp_q.delete(); got_q.delete(); par_q.delete();
      sends = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (send === 1'b1) sends++;
        if (busy === 1'b0) break;
      end
      checks++; if (sends !== 1 || busy !== 1'b0) begin errors++; $display("FAIL rand%0d_tail: sends=%0d busy=%b want 1/0", n, sends, busy); end
    end
  endtask

`ifdef SEND_ROW_PARITY_EN
  task automatic test_parity();
    logic [ROW_W-1:0] r;
    int cyc;
    bit to;
    r = rand_row();
    r[ROW_W-1 -: 32] = 32'h0007_0003;
    @(negedge clk);
    row = r;
    ready = 1'b1;
    pull_words(NWORDS, 0, 1'b0, cyc, to);
    checks++; if (par_q.size() !== NWORDS) begin errors++; $display("FAIL parity_count: got %0d want %0d", par_q.size(), NWORDS); end
    if (par_q.size() >= 2) begin
      checks++; if (got_q[0] !== 16'h0007 || par_q[0] !== 1'b1) begin errors++; $display("FAIL parity_0007: word %h par %b want 0007/1", got_q[0], par_q[0]); end
      checks++; if (got_q[1] !== 16'h0003 || par_q[1] !== 1'b0) begin errors++; $display("FAIL parity_0003: word %h par %b want 0003/0", got_q[1], par_q[1]); end
    end
    exp_q.delete(); got_q.delete(); par_q.delete();
    for (int i = 0; i < 20 && busy !== 1'b0; i++) @(negedge clk);
    checks++; if (out_parity !== 1'b0) begin errors++; $display("FAIL parity_idle: got %b want 0", out_parity); end
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_single_row();
    test_backpressure();
    test_back_to_back();
    test_disturb();
    test_random_rows();
`ifdef SEND_ROW_PARITY_EN
    test_parity();
`endif
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
